// File: rtl/mips_pkg.sv
// mips_pkg: shared load-type encodings, register constants and alignment helper
package mips_pkg;
  localparam int WORD_W = 32;
  localparam logic [2:0] LD_W = 3'd0, LD_H = 3'd1, LD_HU = 3'd2, LD_B = 3'd3, LD_BU = 3'd4;
  localparam logic [4:0] REG_ZERO = 5'd0;
  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] off);
    return (t == LD_W && off != 2'd0) || ((t == LD_H || t == LD_HU) && off[0]);
  endfunction
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: MEM-side inputs and register-file write port of the MEM/WB stage
// Bypass ports exist only when WB_BYPASS_EN is defined.
interface mem_wb_stage_if #(parameter int CNT_W = 32);
  import mips_pkg::*;
  logic memValid, memRegWrite, memMemToReg, wbHold, wbFlush;
  logic [2:0] memLoadType;
  logic [1:0] memByteOff;
  logic [WORD_W-1:0] memAluResult, memReadData, writeData;
  logic [4:0] memWriteReg, writeReg;
  logic RegWrite, wbValid, alignErr;
  logic [CNT_W-1:0] retireCount;
`ifdef WB_BYPASS_EN
  logic [4:0] readReg1, readReg2;
  logic [WORD_W-1:0] rfData1, rfData2, fwdData1, fwdData2;
`endif
  modport master(
    output memValid, memRegWrite, memMemToReg, memLoadType, memByteOff, memAluResult,
    output memReadData, memWriteReg, wbHold, wbFlush,
`ifdef WB_BYPASS_EN
    output readReg1, readReg2, rfData1, rfData2,
    input fwdData1, fwdData2,
`endif
    input writeReg, writeData, RegWrite, wbValid, alignErr, retireCount
  );
  modport slave(
    input memValid, memRegWrite, memMemToReg, memLoadType, memByteOff, memAluResult,
    input memReadData, memWriteReg, wbHold, wbFlush,
`ifdef WB_BYPASS_EN
    input readReg1, readReg2, rfData1, rfData2,
    output fwdData1, fwdData2,
`endif
    output writeReg, writeData, RegWrite, wbValid, alignErr, retireCount
  );
endinterface

// File: rtl/mem_wb_stage_load_extract.sv
// load_extract: big-endian byte/half lane select with sign or zero extension
module load_extract
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [2:0]        loadType,
  input  logic [1:0]        off,
  output logic [WORD_W-1:0] result
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = 8'(word >> {~off, 3'b000});
    h = off[1] ? word[15:0] : word[31:16];
    result = loadType == LD_B  ? {{24{b[7]}}, b} :
             loadType == LD_BU ? {24'b0, b} :
             loadType == LD_H  ? {{16{h[15]}}, h} :
             loadType == LD_HU ? {16'b0, h} : word;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB register, load formatting, $0 suppression and retire counter
// Optional write-before-read bypass around the register file under WB_BYPASS_EN.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic CLK,
  input logic MasterReset,
  mem_wb_stage_if.slave bus
);
  logic validQ, doneQ, regWriteQ, memToRegQ, align, wr;
  logic [2:0] typeQ;
  logic [1:0] offQ;
  logic [WORD_W-1:0] aluQ, readQ, loadData, result;
  logic [4:0] writeRegQ;
  logic [CNT_W-1:0] retireQ;
  always_ff @(posedge CLK or posedge MasterReset)
    if (MasterReset) begin
      validQ <= 1'b0;
      doneQ <= 1'b0;
      regWriteQ <= 1'b0;
      memToRegQ <= 1'b0;
      typeQ <= 3'd0;
      offQ <= 2'd0;
      aluQ <= '0;
      readQ <= '0;
      writeRegQ <= REG_ZERO;
      retireQ <= '0;
    end else begin
      if (validQ && !doneQ) retireQ <= retireQ + CNT_W'(1);
      if (bus.wbFlush) begin
        validQ <= 1'b0;
        doneQ <= 1'b0;
      end else if (bus.wbHold) begin
        doneQ <= validQ;
      end else begin
        validQ <= bus.memValid;
        doneQ <= 1'b0;
        regWriteQ <= bus.memRegWrite;
        memToRegQ <= bus.memMemToReg;
        typeQ <= bus.memLoadType;
        offQ <= bus.memByteOff;
        aluQ <= bus.memAluResult;
        readQ <= bus.memReadData;
        writeRegQ <= bus.memWriteReg;
      end
    end
  load_extract u_extract (.word(readQ), .loadType(typeQ), .off(offQ), .result(loadData));
  // doneQ marks a held instruction that already wrote, so it pulses only once
  always_comb begin
    result = memToRegQ ? loadData : aluQ;
    align = validQ & memToRegQ & misaligned(typeQ, offQ);
    wr = validQ & regWriteQ & ~doneQ & ~align & (writeRegQ != REG_ZERO);
  end
  assign bus.writeReg = writeRegQ;
  assign bus.writeData = result;
  assign bus.RegWrite = wr;
  assign bus.wbValid = validQ;
  assign bus.alignErr = align;
  assign bus.retireCount = retireQ;
`ifdef WB_BYPASS_EN
  assign bus.fwdData1 = (wr && writeRegQ == bus.readReg1) ? result : bus.rfData1;
  assign bus.fwdData2 = (wr && writeRegQ == bus.readReg2) ? result : bus.rfData2;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage (bypass checks under WB_BYPASS_EN)
module tb_mem_wb_stage;
  import mips_pkg::*;
  typedef struct {
    logic [4:0] r;
    logic [31:0] d;
  } wr_t;
  logic CLK = 1'b0, MasterReset = 1'b1;
  int nTests = 0, nFail = 0, expRet = 0;
  wr_t sb[$];
  wr_t e;
  always #5 CLK = ~CLK;
  mem_wb_stage_if #(.CNT_W(32)) bus();
  mem_wb_stage #(.CNT_W(32)) dut (.CLK(CLK), .MasterReset(MasterReset), .bus(bus));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] t,
                       input logic [1:0] off, input logic [31:0] alu, input logic [31:0] rd,
                       input logic [4:0] wrReg, input logic ww, input logic [31:0] exp);
    @(negedge CLK);
    bus.memValid = v;
    bus.memRegWrite = rw;
    bus.memMemToReg = m2r;
    bus.memLoadType = t;
    bus.memByteOff = off;
    bus.memAluResult = alu;
    bus.memReadData = rd;
    bus.memWriteReg = wrReg;
    bus.wbHold = 1'b0;
    bus.wbFlush = 1'b0;
    if (ww) sb.push_back('{wrReg, exp});
    if (v) expRet++;
  endtask

  task automatic idle();
    drive(0, 0, 0, LD_W, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge CLK)
    if (!MasterReset && bus.RegWrite === 1'b1) begin
      if (sb.size() == 0) check("spurious RegWrite", bus.writeReg, 0);
      else begin
        e = sb.pop_front();
        check("writeReg", bus.writeReg, e.r);
        check("writeData", bus.writeData, e.d);
      end
    end

  initial begin
    bus.memValid = 0; bus.memRegWrite = 0; bus.memMemToReg = 0; bus.memLoadType = 0;
    bus.memByteOff = 0; bus.memAluResult = 0; bus.memReadData = 0; bus.memWriteReg = 0;
    bus.wbHold = 0; bus.wbFlush = 0;
`ifdef WB_BYPASS_EN
    bus.readReg1 = 0; bus.readReg2 = 0; bus.rfData1 = 0; bus.rfData2 = 0;
`endif
    #12;
    check("rst RegWrite", bus.RegWrite, 0);
    check("rst wbValid", bus.wbValid, 0);
    check("rst alignErr", bus.alignErr, 0);
    check("rst writeReg", bus.writeReg, 0);
    check("rst writeData", bus.writeData, 0);
    check("rst retireCount", bus.retireCount, 0);
    @(negedge CLK) MasterReset = 0;
    drive(1, 1, 0, LD_W, 0, 32'h1234_5678, 0, 5, 1, 32'h1234_5678);
    idle(); idle();
    check("retire alu", bus.retireCount, 1);
    drive(1, 1, 1, LD_B,  0, 0, 32'h80FF_7F01, 10, 1, 32'hFFFF_FF80);
    drive(1, 1, 1, LD_BU, 1, 0, 32'h80FF_7F01, 11, 1, 32'h0000_00FF);
    drive(1, 1, 1, LD_H,  2, 0, 32'h80FF_7F01, 12, 1, 32'h0000_7F01);
    drive(1, 1, 1, LD_HU, 0, 0, 32'h80FF_7F01, 13, 1, 32'h0000_80FF);
    drive(1, 1, 1, LD_W,  0, 0, 32'h80FF_7F01, 14, 1, 32'h80FF_7F01);
    drive(1, 1, 1, 3'd7,  0, 0, 32'hA5A5_0F0F, 16, 1, 32'hA5A5_0F0F);
    idle(); idle();
    check("retire loads", bus.retireCount, 7);
    drive(1, 1, 1, LD_W, 2, 0, 32'h1111_2222, 7, 0, 0);
    @(posedge CLK) #1;
    check("misaligned alignErr", bus.alignErr, 1);
    check("misaligned RegWrite", bus.RegWrite, 0);
    drive(1, 1, 1, LD_H, 1, 0, 32'h1111_2222, 8, 0, 0);
    @(posedge CLK) #1;
    check("misaligned half", bus.alignErr, 1);
    idle(); idle();
    check("retire misaligned", bus.retireCount, 9);
    drive(1, 1, 0, LD_W, 0, 32'h55, 0, 0, 0, 0);
    @(posedge CLK) #1;
    check("r0 RegWrite", bus.RegWrite, 0);
    check("r0 wbValid", bus.wbValid, 1);
    drive(1, 1, 0, LD_W, 0, 32'hCAFE, 0, 20, 1, 32'hCAFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      bus.memWriteReg = 21; bus.memAluResult = 32'hDEAD; bus.wbHold = 1;
      @(posedge CLK) #1;
      check("hold RegWrite", bus.RegWrite, 0);
      check("hold writeReg", bus.writeReg, 20);
      check("hold writeData", bus.writeData, 32'hCAFE);
    end
    idle(); idle();
    check("retire hold", bus.retireCount, expRet);
    drive(1, 1, 0, LD_W, 0, 32'h22, 0, 22, 1, 32'h22);
    @(negedge CLK);
    bus.memWriteReg = 23; bus.memAluResult = 32'h23; bus.wbHold = 1; bus.wbFlush = 1;
    @(posedge CLK) #1;
    check("flush wbValid", bus.wbValid, 0);
    check("flush RegWrite", bus.RegWrite, 0);
    idle(); idle();
    check("retire flush", bus.retireCount, expRet);
`ifdef WB_BYPASS_EN
    drive(1, 1, 0, LD_W, 0, 32'h9999, 0, 9, 1, 32'h9999);
    @(posedge CLK) #1;
    bus.readReg1 = 9; bus.rfData1 = 0; bus.readReg2 = 8; bus.rfData2 = 32'hAAAA;
    #1;
    check("bypass fwd1", bus.fwdData1, 32'h9999);
    check("bypass fwd2", bus.fwdData2, 32'hAAAA);
    bus.readReg1 = 0; bus.rfData1 = 32'h1111;
    #1;
    check("bypass r0", bus.fwdData1, 32'h1111);
`endif
    drive(1, 1, 0, LD_W, 0, 32'h15, 0, 15, 1, 32'h15);
    @(negedge CLK) bus.wbHold = 1;
    @(posedge CLK) #1 MasterReset = 1;
    #1;
    check("midrst RegWrite", bus.RegWrite, 0);
    check("midrst wbValid", bus.wbValid, 0);
    check("midrst writeReg", bus.writeReg, 0);
    check("midrst writeData", bus.writeData, 0);
    check("midrst retire", bus.retireCount, 0);
    @(negedge CLK) MasterReset = 0;
    idle(); idle();
    check("post-rst retire", bus.retireCount, 0);
    check("post-rst wbValid", bus.wbValid, 0);
    check("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
